instr_fetch: RTL and testbench

Instruction fetch stage that sits downstream of the 8-bit program counter. Each cycle it can issue one synchronous instruction-memory read at the current PC, pulse the counter's advance enable, and capture the returned word into a small buffer. The buffer feeds decode through a valid/ready handshake. The block stops fetching on backpressure, flush, or a HALT opcode.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buf.sv | 50 +++++
 rtl/instr_fetch.sv | 130 +++++++++++++
 tb/tb_instr_fetch.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch stage.
package fetch_pkg;

  localparam int          DEF_ADDR_W  = 8;
  localparam int          DEF_DATA_W  = 16;
  localparam logic [15:0] DEF_HALT_OP = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry circular instruction buffer; push and pop may coincide, clear empties it.
module fetch_buf #(
  parameter  int W     = 24,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [PW:0]   count
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW:0]   count_r;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues PC reads, buffers returns, stops on HALT_OP or flush.
// Optional FETCH_PARITY_EN: mem_rdata carries an even-parity MSB and instr_err flags bad words.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter int                DATA_W  = DEF_DATA_W,
  parameter int                DEPTH   = 2,
  parameter logic [DATA_W-1:0] HALT_OP = DATA_W'(DEF_HALT_OP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
`ifdef FETCH_PARITY_EN
  input  logic [DATA_W:0]   mem_rdata,
`else
  input  logic [DATA_W-1:0] mem_rdata,
`endif
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic              instr_err
);

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef FETCH_PARITY_EN
  localparam int BW = DATA_W + ADDR_W + 1;

  function automatic logic par_err(input logic [DATA_W:0] w);
    return ^w;
  endfunction
`else
  localparam int BW = DATA_W + ADDR_W;
`endif

  fetch_state_t      state_r, state_next_s;
  logic              inflight_r;
  logic [ADDR_W-1:0] iss_addr_r;
  logic [CW-1:0]     count_s;
  logic [CW:0]       occ_s;
  logic [BW-1:0]     head_s, push_data_s;
  logic              pop_s, push_s, issue_s, halt_word_s;

  assign instr_valid = (count_s != CW'(0));
  assign pop_s       = instr_valid & instr_ready;
  assign occ_s       = (CW+1)'(count_s) + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
  // A flush in the return cycle drops the word that is arriving.
  assign push_s      = inflight_r & ~flush;
  assign halt_word_s = push_s && (mem_rdata[DATA_W-1:0] == HALT_OP);

  always_comb begin
    issue_s  = 1'b0;
    mem_rd   = 1'b0;
    pc_en    = 1'b0;
    mem_addr = '0;
    if ((state_r == RUN) && !flush && (occ_s < (CW+1)'(DEPTH))) begin
      issue_s  = 1'b1;
      mem_rd   = 1'b1;
      pc_en    = 1'b1;
      mem_addr = pc;
    end else begin
      issue_s  = 1'b0;
    end
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (flush)            state_next_s = start ? RUN : IDLE;
        else if (halt_word_s) state_next_s = HALT;
        else                  state_next_s = RUN;
      end
      HALT: begin
        if (flush) state_next_s = start ? RUN : IDLE;
        else       state_next_s = HALT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      inflight_r <= 1'b0;
      iss_addr_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (flush) inflight_r <= 1'b0;
      else       inflight_r <= issue_s;
      if (issue_s) iss_addr_r <= pc;
      else         iss_addr_r <= iss_addr_r;
    end
  end

`ifdef FETCH_PARITY_EN
  assign push_data_s = {par_err(mem_rdata), iss_addr_r, mem_rdata[DATA_W-1:0]};
  assign instr_err   = head_s[BW-1] & instr_valid;
`else
  assign push_data_s = {iss_addr_r, mem_rdata};
  assign instr_err   = 1'b0;
`endif

  fetch_buf #(.W(BW), .DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s)
  );

  assign instr    = head_s[DATA_W-1:0];
  assign instr_pc = head_s[DATA_W +: ADDR_W];
  assign halted   = (state_r == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a PC counter and 1-cycle ROM model.
module tb_instr_fetch;

`ifdef FETCH_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, flush, instr_ready;
  logic [7:0]  pc;
  logic        pc_en, mem_rd, instr_valid, halted, instr_err;
  logic [7:0]  mem_addr, instr_pc;
  logic [15:0] instr;
`ifdef FETCH_PARITY_EN
  logic [16:0] mem_rdata;
  logic        bad_par [256];
`else
  logic [15:0] mem_rdata;
`endif
  logic        pc_load;
  logic [7:0]  pc_load_val;
  logic [15:0] rom [256];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .pc(pc),
    .pc_en(pc_en), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .halted(halted), .instr_err(instr_err)
  );

  // Upstream program counter: advances on pc_en, reloads on redirect.
  always @(posedge clk or negedge reset) begin
    if (!reset)       pc <= 8'd0;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_en)   pc <= pc + 8'd1;
  end

  always @(posedge clk) begin
    if (mem_rd) begin
`ifdef FETCH_PARITY_EN
      mem_rdata <= {(^rom[mem_addr]) ^ bad_par[mem_addr], rom[mem_addr]};
`else
      mem_rdata <= rom[mem_addr];
`endif
    end else begin
      mem_rdata <= '0;
    end
  end

  task automatic init_rom();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'h0100 + 16'(i);
`ifdef FETCH_PARITY_EN
      bad_par[i] = 1'b0;
`endif
    end
  endtask

  // Ends on a falling edge with reset released; that cycle is cycle 0.
  task automatic do_reset();
    reset = 1'b0; start = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    pc_load = 1'b0; pc_load_val = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    init_rom();
    reset = 1'b0; start = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    pc_load = 1'b0; pc_load_val = 8'd0;
    @(negedge clk); #1;
    total++;
    if ({pc_en, mem_rd, mem_addr} !== 10'd0) begin
      bad++; $display("FAIL reset_mem got %h want 000", {pc_en, mem_rd, mem_addr});
    end
    total++;
    if ({instr_valid, instr, instr_pc} !== 25'd0) begin
      bad++; $display("FAIL reset_instr got %h want 0", {instr_valid, instr, instr_pc});
    end
    total++;
    if ({halted, instr_err} !== 2'b00) begin
      bad++; $display("FAIL reset_flags got %b want 00", {halted, instr_err});
    end
  endtask

  task automatic test_stream();
    logic [15:0] ei;
    logic [7:0]  ep;
    init_rom();
`ifdef FETCH_PARITY_EN
    bad_par[2] = 1'b1;
`endif
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0); instr_ready = 1'b1;
      #1;
      if (c == 0) begin
        total++;
        if (mem_rd !== 1'b0) begin bad++; $display("FAIL stream_idle_rd got %b want 0", mem_rd); end
      end else begin
        total++;
        if ({mem_rd, pc_en, mem_addr} !== {2'b11, 8'(c - 1)}) begin
          bad++; $display("FAIL stream_issue c=%0d got %h want %h", c, {mem_rd, pc_en, mem_addr}, {2'b11, 8'(c - 1)});
        end
      end
      if (c == 1 || c == 2) begin
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid c=%0d got 1 want 0", c); end
      end
      if (c >= 3) begin
        ei = 16'h0100 + 16'(c - 3); ep = 8'(c - 3);
        total++;
        if ({instr_valid, instr, instr_pc, instr_err} !== {1'b1, ei, ep, PAR && (c == 5)}) begin
          bad++;
          $display("FAIL stream_data c=%0d got v=%b i=%h pc=%h e=%b want v=1 i=%h pc=%h e=%b",
                   c, instr_valid, instr, instr_pc, instr_err, ei, ep, PAR && (c == 5));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ei;
    init_rom();
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      start = (c == 0); instr_ready = !(c >= 4 && c <= 8);
      #1;
      if (c == 3) begin
        total++;
        if (instr !== 16'h0100) begin bad++; $display("FAIL bp_first got %h want 0100", instr); end
      end
      if (c >= 4 && c <= 8) begin
        total++;
        if ({instr_valid, instr, instr_pc, mem_rd, pc_en} !== {1'b1, 16'h0101, 8'h01, 2'b00}) begin
          bad++;
          $display("FAIL bp_hold c=%0d got v=%b i=%h pc=%h rd=%b en=%b want v=1 i=0101 pc=01 rd=0 en=0",
                   c, instr_valid, instr, instr_pc, mem_rd, pc_en);
        end
      end
      if (c == 9) begin
        total++;
        if ({mem_rd, mem_addr} !== {1'b1, 8'h03}) begin
          bad++; $display("FAIL bp_resume_issue got %h want 103", {mem_rd, mem_addr});
        end
      end
      if (c >= 9) begin
        ei = 16'h0101 + 16'(c - 9);
        total++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, ei, 8'(1 + c - 9)}) begin
          bad++;
          $display("FAIL bp_order c=%0d got v=%b i=%h pc=%h want v=1 i=%h pc=%h",
                   c, instr_valid, instr, instr_pc, ei, 8'(1 + c - 9));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    init_rom();
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      start = (c == 0 || c == 7); flush = (c == 7); instr_ready = 1'b1;
      pc_load = (c == 7); pc_load_val = 8'h40;
      #1;
      if (c == 6) begin
        total++;
        if ({mem_rd, mem_addr} !== {1'b1, 8'h05}) begin
          bad++; $display("FAIL flush_pre_issue got %h want 105", {mem_rd, mem_addr});
        end
      end
      if (c == 7) begin
        total++;
        if ({mem_rd, pc_en} !== 2'b00) begin
          bad++; $display("FAIL flush_cycle got rd=%b en=%b want 00", mem_rd, pc_en);
        end
      end
      if (c == 8) begin
        total++;
        if ({instr_valid, mem_rd, mem_addr} !== {2'b01, 8'h40}) begin
          bad++; $display("FAIL flush_redirect got %h want 140", {instr_valid, mem_rd, mem_addr});
        end
      end
      if (c == 9) begin
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got valid=1 want 0"); end
      end
      if (c == 10) begin
        total++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h0140, 8'h40}) begin
          bad++; $display("FAIL flush_next got v=%b i=%h pc=%h want v=1 i=0140 pc=40", instr_valid, instr, instr_pc);
        end
      end
      @(negedge clk);
    end
    flush = 1'b0; pc_load = 1'b0;
  endtask

  task automatic test_halt();
    logic [15:0] ei;
    init_rom();
    rom[3] = 16'hFFFF;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0); instr_ready = 1'b1;
      #1;
      if (c == 4) begin
        total++;
        if ({mem_rd, mem_addr} !== {1'b1, 8'h03}) begin
          bad++; $display("FAIL halt_issue got %h want 103", {mem_rd, mem_addr});
        end
      end
      if (c == 5) begin
        total++;
        if (halted !== 1'b0) begin bad++; $display("FAIL halt_early got 1 want 0"); end
      end
      if (c >= 3 && c <= 6) begin
        ei = (c == 6) ? 16'hFFFF : 16'h0100 + 16'(c - 3);
        total++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, ei, 8'(c - 3)}) begin
          bad++;
          $display("FAIL halt_words c=%0d got v=%b i=%h pc=%h want v=1 i=%h pc=%h",
                   c, instr_valid, instr, instr_pc, ei, 8'(c - 3));
        end
      end
      if (c >= 6) begin
        total++;
        if ({halted, mem_rd, pc_en} !== 3'b100) begin
          bad++; $display("FAIL halt_stop c=%0d got %b want 100", c, {halted, mem_rd, pc_en});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midop();
    init_rom();
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      start = (c == 0); instr_ready = 1'b0;
      #1;
      if (c == 3) begin
        total++;
        if (instr_valid !== 1'b1) begin bad++; $display("FAIL midop_pre got valid=0 want 1"); end
        reset = 1'b0;
        #1;
        total++;
        if ({pc_en, mem_rd, mem_addr, instr_valid, instr, instr_pc, halted, instr_err} !== 37'd0) begin
          bad++;
          $display("FAIL midop_async got %h want 0",
                   {pc_en, mem_rd, mem_addr, instr_valid, instr, instr_pc, halted, instr_err});
        end
        #1 reset = 1'b1;
      end
      if (c >= 4) begin
        total++;
        if ({instr_valid, mem_rd, halted} !== 3'b000) begin
          bad++; $display("FAIL midop_ignore c=%0d got %b want 000", c, {instr_valid, mem_rd, halted});
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_halt();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
